// File: rtl/lut_sweep_pkg.sv
// Shared state encoding and sizing helpers for the LUT sweep checker.
package lut_sweep_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  localparam int PCNTW = 4;

  function automatic int vec_of(input int n);
    return 1 << n;
  endfunction

  // Counter width able to hold settle-1; never narrower than one bit.
  function automatic int cntw_of(input int settle);
    return (settle <= 2) ? 1 : $clog2(settle);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] mx;
    mx = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= mx) ? mx : v + 32'd1;
  endfunction

endpackage

// File: rtl/lut_sweep_settle_timer.sv
// Loadable down-counter with zero flag; stops at zero.
module lut_sweep_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lut_sweep_checker.sv
// Sweeps all inputs of an external N-input LUT, waits a settle interval per
// vector, and checks the sampled output against the INIT truth table.
module lut_sweep_checker
  import lut_sweep_pkg::*;
#(
  parameter int                 N      = 1,
  parameter logic [(1<<N)-1:0]  INIT   = 2'b01,
  parameter int                 SETTLE = 4,
  parameter int                 PASSES = 1,
  parameter int                 ERRW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N-1:0]    lut_i,
  input  logic            lut_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic            first_err_valid,
  output logic [N-1:0]    first_err_idx
);

  localparam int VEC  = vec_of(N);
  localparam int CNTW = cntw_of(SETTLE);
  localparam logic [CNTW-1:0]  RELOAD    = CNTW'(SETTLE - 1);
  localparam logic [N-1:0]     IDX_LAST  = N'(VEC - 1);
  localparam logic [PCNTW-1:0] PASS_LAST = PCNTW'(PASSES - 1);

  state_t            state;
  logic [N-1:0]      idx;
  logic [PCNTW-1:0]  pcnt;
  logic [CNTW-1:0]   scnt;
  logic              szero;
  logic              mism;
  logic              last;
  logic              go;
  logic              tload;
  logic [ERRW-1:0]   err_next;

  assign go    = (state == ST_IDLE || state == ST_DONE) && start;
  assign last  = (idx == IDX_LAST) && (pcnt == PASS_LAST);
  assign tload = go || (state == ST_SAMPLE && !last);

  // Simulation treats an unknown LUT output as a failure.
  always_comb begin
`ifndef SYNTHESIS
    mism = (lut_o !== INIT[idx]);
`else
    mism = (lut_o != INIT[idx]);
`endif
  end

  assign err_next = mism ? ERRW'(sat_inc(32'(err_count), ERRW)) : err_count;

  lut_sweep_settle_timer #(.W(CNTW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tload),
    .load_val (RELOAD),
    .en       (state == ST_SETTLE),
    .cnt      (scnt),
    .zero     (szero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      idx             <= '0;
      pcnt            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state           <= ST_SETTLE;
            idx             <= '0;
            pcnt            <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
          end
        end
        ST_SETTLE: begin
          if (szero) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          err_count <= err_next;
          if (mism && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_idx   <= idx;
          end
          if (last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state <= ST_SETTLE;
            idx   <= idx + N'(1);
            if (idx == IDX_LAST) pcnt <= pcnt + PCNTW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign lut_i = idx;

endmodule

// File: tb/tb_lut_sweep_checker.sv
// Directed bench: four checker instances covering default, XOR4, saturation
// and short-settle configurations against simple LUT models.
module tb_lut_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] st = '0;
  int mode = 0;   // model for u0: 0 inverter, 1 stuck-at-1, 2 delayed inverter

  logic       li0, li3, lo0, lo1, lo2, lo3;
  logic [3:0] li1, li2;
  logic       b0, b1, b2, b3, d0, d1, d2, d3, p0, p1, p2, p3;
  logic       v0, v1, v2, v3;
  logic       fi0, fi3;
  logic [3:0] fi1, fi2;
  logic [7:0] ec0, ec1, ec3;
  logic [3:0] ec2;
  logic [2:0] dly0 = 3'b111, dly3 = 3'b111;

  always @(posedge clk) begin
    dly0 <= {dly0[1:0], ~li0};
    dly3 <= {dly3[1:0], ~li3};
  end

  assign lo0 = (mode == 0) ? ~li0 : (mode == 1) ? 1'b1 : dly0[2];
  assign lo1 = ^li1;
  assign lo2 = 1'b0;
  assign lo3 = dly3[2];

  lut_sweep_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .lut_i(li0), .lut_o(lo0),
    .busy(b0), .done(d0), .pass(p0), .err_count(ec0),
    .first_err_valid(v0), .first_err_idx(fi0));

  lut_sweep_checker #(.N(4), .INIT(16'h6996), .SETTLE(2), .PASSES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .lut_i(li1), .lut_o(lo1),
    .busy(b1), .done(d1), .pass(p1), .err_count(ec1),
    .first_err_valid(v1), .first_err_idx(fi1));

  lut_sweep_checker #(.N(4), .INIT(16'hFFFF), .PASSES(2), .ERRW(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .lut_i(li2), .lut_o(lo2),
    .busy(b2), .done(d2), .pass(p2), .err_count(ec2),
    .first_err_valid(v2), .first_err_idx(fi2));

  lut_sweep_checker #(.SETTLE(2)) u3 (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .lut_i(li3), .lut_o(lo3),
    .busy(b3), .done(d3), .pass(p3), .err_count(ec3),
    .first_err_valid(v3), .first_err_idx(fi3));

  logic [3:0] busy_a, done_a, pass_a, fev_a;
  logic [3:0] li_a[4];
  logic [3:0] fi_a[4];
  logic [7:0] err_a[4];
  assign busy_a = {b3, b2, b1, b0};
  assign done_a = {d3, d2, d1, d0};
  assign pass_a = {p3, p2, p1, p0};
  assign fev_a  = {v3, v2, v1, v0};
  assign li_a[0] = {3'b0, li0};
  assign li_a[1] = li1;
  assign li_a[2] = li2;
  assign li_a[3] = {3'b0, li3};
  assign fi_a[0] = {3'b0, fi0};
  assign fi_a[1] = fi1;
  assign fi_a[2] = fi2;
  assign fi_a[3] = {3'b0, fi3};
  assign err_a[0] = ec0;
  assign err_a[1] = ec1;
  assign err_a[2] = {4'b0, ec2};
  assign err_a[3] = ec3;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start unit u, count busy cycles, and track lut_i against the expected
  // vector for each busy cycle. poke re-pulses start mid-run.
  task automatic run(input int u, input int exp_cyc, input int per_vec, input int vec,
                     input bit poke);
    int n;
    int bad;
    bad = 0;
    @(negedge clk); st[u] = 1'b1;
    @(negedge clk); st[u] = 1'b0;
    chk($sformatf("u%0d busy_rise", u), 32'(busy_a[u]), 1);
    chk($sformatf("u%0d done_clr", u), 32'(done_a[u]), 0);
    n = 1;
    if (32'(li_a[u]) != 0) bad++;
    while (busy_a[u] && n < exp_cyc + 50) begin
      @(negedge clk);
      st[u] = (poke && n == 3);
      if (busy_a[u]) begin
        n++;
        if (32'(li_a[u]) != ((n - 1) / per_vec) % vec) bad++;
      end
    end
    st[u] = 1'b0;
    chk($sformatf("u%0d cycles", u), n, exp_cyc);
    chk($sformatf("u%0d lut_i_seq", u), bad, 0);
    chk($sformatf("u%0d done", u), 32'(done_a[u]), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy_a), 0);
    chk("rst done", 32'(done_a), 0);
    chk("rst pass", 32'(pass_a), 0);
    chk("rst fev", 32'(fev_a), 0);
    chk("rst err1", 32'(err_a[1]), 0);
    chk("rst lut_i1", 32'(li_a[1]), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle busy", 32'(busy_a), 0);

    // default inverter, correct model
    mode = 0;
    run(0, 10, 5, 2, 0);
    chk("u0 pass", 32'(pass_a[0]), 1);
    chk("u0 err", 32'(err_a[0]), 0);
    chk("u0 fev", 32'(fev_a[0]), 0);
    chk("u0 last lut_i", 32'(li_a[0]), 1);

    // start ignored while busy; also a rerun from DONE
    run(0, 10, 5, 2, 1);
    chk("u0 poke pass", 32'(pass_a[0]), 1);

    // stuck-at-1 output
    mode = 1;
    run(0, 10, 5, 2, 0);
    chk("stuck pass", 32'(pass_a[0]), 0);
    chk("stuck err", 32'(err_a[0]), 1);
    chk("stuck fev", 32'(fev_a[0]), 1);
    chk("stuck fidx", 32'(fi_a[0]), 1);

    // delayed model with ample settle time
    mode = 2;
    run(0, 10, 5, 2, 0);
    chk("dly4 pass", 32'(pass_a[0]), 1);
    chk("dly4 err", 32'(err_a[0]), 0);

    // XOR4 two passes
    run(1, 96, 3, 16, 0);
    chk("xor pass", 32'(pass_a[1]), 1);
    chk("xor err", 32'(err_a[1]), 0);

    // saturation
    run(2, 160, 5, 16, 0);
    chk("sat err", 32'(err_a[2]), 15);
    chk("sat fidx", 32'(fi_a[2]), 0);
    chk("sat fev", 32'(fev_a[2]), 1);
    chk("sat pass", 32'(pass_a[2]), 0);

    // delayed model with too-short settle
    run(3, 6, 3, 2, 0);
    chk("dly2 pass", 32'(pass_a[3]), 0);
    chk("dly2 err", 32'(err_a[3]), 1);
    chk("dly2 fidx", 32'(fi_a[3]), 1);

    // async reset mid-sweep
    @(negedge clk); st[1] = 1'b1;
    @(negedge clk); st[1] = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid busy", 32'(busy_a[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(busy_a), 0);
    chk("arst done", 32'(done_a), 0);
    chk("arst lut_i1", 32'(li_a[1]), 0);
    chk("arst err2", 32'(err_a[2]), 0);
    chk("arst fev", 32'(fev_a), 0);
    @(negedge clk); rst_n = 1'b1;
    run(1, 96, 3, 16, 0);
    chk("post-rst pass", 32'(pass_a[1]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
